// File: rtl/triangle_pkg.sv
// Triangle link payload types shared by the serializer and its far-end deserializer.
package triangle_pkg;

  localparam int unsigned COORD_W = 12;
  localparam int unsigned COLOR_W = 8;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [COORD_W-1:0] z;
  } position_t;

  typedef struct packed {
    position_t          position;
    logic [COLOR_W-1:0] color;
  } vertex_t;

  // v0 occupies the MSBs, so v0.position.x leads on the wire.
  typedef struct packed {
    vertex_t v0;
    vertex_t v1;
    vertex_t v2;
  } triangle_t;

  typedef struct packed {
    logic [7:0] model_id;
    logic       last;
  } triangle_metadata_t;

endpackage

// File: rtl/triangle_stream_serializer_if.sv
// Handshake bundle for the triangle serializer: triangle input stream and word output stream.
interface triangle_stream_serializer_if #(
  parameter int unsigned DATA_WIDTH = 8
) ();
  import triangle_pkg::*;

  logic                  s_valid;
  logic                  s_ready;
  triangle_t             s_triangle;
  triangle_metadata_t    s_metadata;

  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_first;
  logic                  m_last;

  // Serializer side: accepts triangles, produces words.
  modport master (
    input  s_valid, s_triangle, s_metadata, m_ready,
    output s_ready, m_valid, m_data, m_first, m_last
  );

  // Environment side: supplies triangles, consumes words.
  modport slave (
    output s_valid, s_triangle, s_metadata, m_ready,
    input  s_ready, m_valid, m_data, m_first, m_last
  );

endinterface

// File: rtl/triangle_stream_serializer.sv
// Transmit end of the triangle link: frames one triangle as a header word
// followed by its payload, MSB first, in DATA_WIDTH-bit words.
module triangle_stream_serializer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter logic [6:0]  SYNC       = 7'b1010101
) (
  input  logic                         clk,
  input  logic                         rstn,
  triangle_stream_serializer_if.master link,
  output logic [15:0]                  frames_sent
);
  import triangle_pkg::*;

  localparam int unsigned PAYLOAD_BITS  = $bits(triangle_t);
  localparam int unsigned PAYLOAD_WORDS = (PAYLOAD_BITS + DATA_WIDTH - 1) / DATA_WIDTH;
  localparam int unsigned SHIFT_W       = PAYLOAD_WORDS * DATA_WIDTH;
  localparam int unsigned CNT_W         = (PAYLOAD_WORDS > 1) ? $clog2(PAYLOAD_WORDS) : 1;
  localparam logic [DATA_WIDTH-2:0] SYNC_BITS = (DATA_WIDTH-1)'(SYNC);

  typedef enum logic [1:0] {
    IDLE,
    HEADER,
    PAYLOAD
  } state_t;

  state_t             state;
  logic [SHIFT_W-1:0] shreg;
  logic [SHIFT_W-1:0] shreg_next;
  logic [CNT_W-1:0]   cnt;

  // Payload image after the current top word has been consumed.
  assign shreg_next = shreg << DATA_WIDTH;

  // Ready only when no frame is in flight; held low while in reset.
  assign link.s_ready = rstn && (state == IDLE);

  // Frame sequencer with registered word outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= IDLE;
      shreg        <= '0;
      cnt          <= '0;
      link.m_valid <= 1'b0;
      link.m_data  <= '0;
      link.m_first <= 1'b0;
      link.m_last  <= 1'b0;
      frames_sent  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (link.s_valid) begin
            shreg        <= SHIFT_W'(link.s_triangle);
            cnt          <= CNT_W'(PAYLOAD_WORDS - 1);
            link.m_data  <= {SYNC_BITS, link.s_metadata.last};
            link.m_valid <= 1'b1;
            link.m_first <= 1'b1;
            link.m_last  <= 1'b0;
            state        <= HEADER;
          end
        end
        HEADER: begin
          if (link.m_ready) begin
            link.m_data  <= shreg[SHIFT_W-1 -: DATA_WIDTH];
            link.m_first <= 1'b0;
            link.m_last  <= (cnt == '0);
            state        <= PAYLOAD;
          end
        end
        PAYLOAD: begin
          if (link.m_ready) begin
            shreg <= shreg_next;
            if (cnt == '0) begin
              link.m_valid <= 1'b0;
              link.m_last  <= 1'b0;
              frames_sent  <= frames_sent + 16'd1;
              state        <= IDLE;
            end else begin
              cnt         <= cnt - CNT_W'(1);
              link.m_data <= shreg_next[SHIFT_W-1 -: DATA_WIDTH];
              link.m_last <= (cnt == CNT_W'(1));
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_triangle_stream_serializer.sv
// Self-checking bench for triangle_stream_serializer against a word-list reference model.
module tb_triangle_stream_serializer;
  import triangle_pkg::*;

  localparam int DW = 8;
  localparam int PB = $bits(triangle_t);
  localparam int PW = (PB + DW - 1) / DW;
  localparam logic [6:0] SYNC = 7'b1010101;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [15:0] frames_sent;

  triangle_stream_serializer_if #(.DATA_WIDTH(DW)) link ();

  triangle_stream_serializer #(.DATA_WIDTH(DW), .SYNC(SYNC)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .link        (link),
    .frames_sent (frames_sent)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic          first;
    logic          last;
    int            cyc;
  } rec_t;

  rec_t        words[$];
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  int          rdy_mode = 0;   // 0: low, 1: high, 2: random
  logic [15:0] exp_frames = '0;

  // Log every output handshake with its edge number.
  always @(posedge clk) begin
    if (rstn && link.m_valid === 1'b1 && link.m_ready === 1'b1)
      words.push_back('{data: link.m_data, first: link.m_first, last: link.m_last, cyc: cyc});
    cyc++;
  end

  // Transport readiness, updated shortly after each rising edge.
  always @(posedge clk) begin
    #2;
    case (rdy_mode)
      1:       link.m_ready = 1'b1;
      2:       link.m_ready = 1'($urandom_range(0, 1));
      default: link.m_ready = 1'b0;
    endcase
  end

  // Reference: zero-pad the triangle to whole words and cut MSB first.
  function automatic logic [DW-1:0] model_word(triangle_t t, int idx);
    logic [PW*DW-1:0] padded;
    padded = (PW*DW)'(t);
    return DW'(padded >> ((PW - 1 - idx) * DW));
  endfunction

  function automatic logic [DW-1:0] model_header(logic is_last);
    return DW'({SYNC, is_last});
  endfunction

  function automatic triangle_t rand_tri();
    logic [159:0] r;
    r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return triangle_t'(PB'(r));
  endfunction

  // Present a triangle at a falling edge and return at the falling edge after acceptance.
  task automatic offer(input triangle_t t, input logic is_last, input bit keep_valid,
                       output bit timed_out);
    int n;
    n = 0;
    link.s_valid    = 1'b1;
    link.s_triangle = t;
    link.s_metadata = '{model_id: 8'($urandom()), last: is_last};
    while (link.s_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    timed_out = (n >= 200);
    @(negedge clk);
    if (!keep_valid) begin
      link.s_valid    = 1'b0;
      link.s_triangle = rand_tri();
      link.s_metadata = '{model_id: 8'($urandom()), last: 1'($urandom())};
    end
  endtask

  task automatic wait_words(input int n, output bit timed_out);
    int k;
    k = 0;
    while (words.size() < n && k < 2000) begin
      @(negedge clk);
      k++;
    end
    timed_out = (words.size() < n);
  endtask

  task automatic test_reset();
    rdy_mode        = 0;
    link.s_valid    = 1'b0;
    link.s_triangle = '0;
    link.s_metadata = '0;
    rstn            = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (link.s_ready !== 1'b0) begin
      failures++; $display("FAIL reset_s_ready_in_reset: got %b expected 0", link.s_ready);
    end
    rstn = 1'b1;
    @(negedge clk);
    checks++;
    if (link.s_ready !== 1'b1) begin
      failures++; $display("FAIL reset_s_ready: got %b expected 1", link.s_ready);
    end
    checks++;
    if ({link.m_valid, link.m_first, link.m_last} !== 3'b000) begin
      failures++; $display("FAIL reset_flags: got %b expected 000", {link.m_valid, link.m_first, link.m_last});
    end
    checks++;
    if (link.m_data !== '0) begin
      failures++; $display("FAIL reset_m_data: got %h expected 00", link.m_data);
    end
    checks++;
    if (frames_sent !== 16'h0000) begin
      failures++; $display("FAIL reset_frames_sent: got %h expected 0000", frames_sent);
    end
    exp_frames = '0;
  endtask

  task automatic test_single_frame();
    triangle_t t;
    bit        to;
    int        acc;
    t = '0;
    t.v0.position.x = '1;
    rdy_mode = 1;
    words.delete();
    offer(t, 1'b1, 1'b0, to);
    acc = cyc - 1;
    checks++;
    if (to) begin failures++; $display("FAIL single_accept: timed out"); end
    wait_words(PW + 1, to);
    checks++;
    if (words.size() != PW + 1) begin
      failures++; $display("FAIL single_count: got %0d expected %0d", words.size(), PW + 1);
    end
    exp_frames = exp_frames + 16'd1;
    if (words.size() >= 3) begin
      checks++;
      if (words[0].data !== 8'hAB) begin
        failures++; $display("FAIL single_header: got %h expected ab", words[0].data);
      end
      checks++;
      if (words[1].data !== 8'h0F || words[2].data !== 8'hFF) begin
        failures++; $display("FAIL single_pad_words: got %h %h expected 0f ff", words[1].data, words[2].data);
      end
    end
    for (int i = 0; i < words.size() && i <= PW; i++) begin
      logic [DW-1:0] e;
      e = (i == 0) ? model_header(1'b1) : model_word(t, i - 1);
      checks++;
      if ({words[i].data, words[i].first, words[i].last} !== {e, (i == 0), (i == PW)}) begin
        failures++;
        $display("FAIL single_word%0d: got %h f%b l%b expected %h f%b l%b", i,
                 words[i].data, words[i].first, words[i].last, e, (i == 0), (i == PW));
      end
    end
    if (words.size() == PW + 1) begin
      checks++;
      if (words[0].cyc !== acc + 1 || words[PW].cyc !== acc + 1 + PW) begin
        failures++;
        $display("FAIL single_latency: got %0d/%0d expected %0d/%0d",
                 words[0].cyc, words[PW].cyc, acc + 1, acc + 1 + PW);
      end
    end
    checks++;
    if (frames_sent !== exp_frames) begin
      failures++; $display("FAIL single_frames_sent: got %h expected %h", frames_sent, exp_frames);
    end
    checks++;
    if (link.m_valid !== 1'b0 || link.s_ready !== 1'b1) begin
      failures++; $display("FAIL single_back_to_idle: got v%b r%b expected v0 r1", link.m_valid, link.s_ready);
    end
  endtask

  task automatic test_backpressure();
    triangle_t     t;
    bit            to;
    bit            prev_stall;
    logic [DW-1:0] pd;
    logic          pf, pl;
    int            k;
    t = '0;
    t.v0.position.x = '1;
    rdy_mode = 2;
    words.delete();
    offer(t, 1'b1, 1'b0, to);
    checks++;
    if (to) begin failures++; $display("FAIL bp_accept: timed out"); end
    prev_stall = 1'b0; pd = '0; pf = 1'b0; pl = 1'b0;
    k = 0;
    while (words.size() < PW + 1 && k < 2000) begin
      if (prev_stall) begin
        checks++;
        if ({link.m_valid, link.m_data, link.m_first, link.m_last} !== {1'b1, pd, pf, pl}) begin
          failures++;
          $display("FAIL bp_stall_hold: got v%b %h f%b l%b expected v1 %h f%b l%b",
                   link.m_valid, link.m_data, link.m_first, link.m_last, pd, pf, pl);
        end
      end
      prev_stall = link.m_valid && !link.m_ready;
      pd = link.m_data; pf = link.m_first; pl = link.m_last;
      @(negedge clk);
      k++;
    end
    rdy_mode = 1;
    checks++;
    if (words.size() != PW + 1) begin
      failures++; $display("FAIL bp_count: got %0d expected %0d", words.size(), PW + 1);
    end
    exp_frames = exp_frames + 16'd1;
    for (int i = 0; i < words.size() && i <= PW; i++) begin
      logic [DW-1:0] e;
      e = (i == 0) ? model_header(1'b1) : model_word(t, i - 1);
      checks++;
      if ({words[i].data, words[i].first, words[i].last} !== {e, (i == 0), (i == PW)}) begin
        failures++;
        $display("FAIL bp_word%0d: got %h f%b l%b expected %h", i,
                 words[i].data, words[i].first, words[i].last, e);
      end
    end
    checks++;
    if (frames_sent !== exp_frames) begin
      failures++; $display("FAIL bp_frames_sent: got %h expected %h", frames_sent, exp_frames);
    end
  endtask

  task automatic test_random_frames();
    for (int f = 0; f < 4; f++) begin
      triangle_t t;
      logic      lst;
      bit        to;
      t = rand_tri();
      lst = 1'($urandom());
      rdy_mode = 2;
      words.delete();
      offer(t, lst, 1'b0, to);
      wait_words(PW + 1, to);
      rdy_mode = 1;
      checks++;
      if (to || words.size() != PW + 1) begin
        failures++; $display("FAIL rand%0d_count: got %0d expected %0d", f, words.size(), PW + 1);
      end
      exp_frames = exp_frames + 16'd1;
      for (int i = 0; i < words.size() && i <= PW; i++) begin
        logic [DW-1:0] e;
        e = (i == 0) ? model_header(lst) : model_word(t, i - 1);
        checks++;
        if ({words[i].data, words[i].first, words[i].last} !== {e, (i == 0), (i == PW)}) begin
          failures++;
          $display("FAIL rand%0d_word%0d: got %h f%b l%b expected %h", f, i,
                   words[i].data, words[i].first, words[i].last, e);
        end
      end
      checks++;
      if (frames_sent !== exp_frames) begin
        failures++; $display("FAIL rand%0d_frames_sent: got %h expected %h", f, frames_sent, exp_frames);
      end
    end
  endtask

  task automatic test_back_to_back();
    triangle_t t1, t2;
    bit        to1, to2, to3;
    t1 = rand_tri();
    t2 = rand_tri();
    rdy_mode = 1;
    words.delete();
    offer(t1, 1'b0, 1'b1, to1);
    offer(t2, 1'b1, 1'b0, to2);
    wait_words(2 * (PW + 1), to3);
    checks++;
    if (to1 || to2 || to3 || words.size() != 2 * (PW + 1)) begin
      failures++; $display("FAIL b2b_count: got %0d expected %0d", words.size(), 2 * (PW + 1));
    end
    exp_frames = exp_frames + 16'd2;
    for (int i = 0; i < words.size() && i < 2 * (PW + 1); i++) begin
      int            fr, j;
      logic [DW-1:0] e;
      fr = i / (PW + 1);
      j  = i % (PW + 1);
      e  = (j == 0) ? model_header(fr == 1) : model_word((fr == 1) ? t2 : t1, j - 1);
      checks++;
      if ({words[i].data, words[i].first, words[i].last} !== {e, (j == 0), (j == PW)}) begin
        failures++;
        $display("FAIL b2b_word%0d: got %h f%b l%b expected %h", i,
                 words[i].data, words[i].first, words[i].last, e);
      end
    end
    if (words.size() == 2 * (PW + 1)) begin
      checks++;
      if (words[0].data !== 8'hAA || words[PW+1].data !== 8'hAB) begin
        failures++; $display("FAIL b2b_headers: got %h %h expected aa ab", words[0].data, words[PW+1].data);
      end
      checks++;
      if (words[PW+1].cyc - words[PW].cyc !== 2) begin
        failures++; $display("FAIL b2b_gap: got %0d expected 2", words[PW+1].cyc - words[PW].cyc);
      end
    end
    checks++;
    if (frames_sent !== exp_frames) begin
      failures++; $display("FAIL b2b_frames_sent: got %h expected %h", frames_sent, exp_frames);
    end
  endtask

  task automatic test_reset_mid_frame();
    triangle_t t;
    bit        to;
    t = rand_tri();
    rdy_mode = 1;
    words.delete();
    offer(t, 1'b1, 1'b0, to);
    wait_words(3, to);
    checks++;
    if (to || link.m_valid !== 1'b1 || link.m_data !== model_word(t, 2)) begin
      failures++; $display("FAIL mid_word3: got v%b %h expected v1 %h", link.m_valid, link.m_data, model_word(t, 2));
    end
    #2 rstn = 1'b0;
    #1;
    checks++;
    if (link.m_valid !== 1'b0 || link.s_ready !== 1'b0) begin
      failures++; $display("FAIL mid_async_clear: got v%b r%b expected v0 r0", link.m_valid, link.s_ready);
    end
    checks++;
    if (frames_sent !== 16'h0000) begin
      failures++; $display("FAIL mid_frames_clear: got %h expected 0000", frames_sent);
    end
    exp_frames = '0;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    checks++;
    if (link.m_valid !== 1'b0) begin
      failures++; $display("FAIL mid_idle_after_release: got %b expected 0", link.m_valid);
    end
    words.delete();
    t = rand_tri();
    offer(t, 1'b0, 1'b0, to);
    wait_words(PW + 1, to);
    checks++;
    if (to || words.size() != PW + 1) begin
      failures++; $display("FAIL mid_fresh_count: got %0d expected %0d", words.size(), PW + 1);
    end
    exp_frames = exp_frames + 16'd1;
    for (int i = 0; i < words.size() && i <= PW; i++) begin
      logic [DW-1:0] e;
      e = (i == 0) ? model_header(1'b0) : model_word(t, i - 1);
      checks++;
      if ({words[i].data, words[i].first, words[i].last} !== {e, (i == 0), (i == PW)}) begin
        failures++;
        $display("FAIL mid_fresh_word%0d: got %h f%b l%b expected %h", i,
                 words[i].data, words[i].first, words[i].last, e);
      end
    end
    checks++;
    if (frames_sent !== exp_frames) begin
      failures++; $display("FAIL mid_frames_sent: got %h expected %h", frames_sent, exp_frames);
    end
  endtask

  task automatic test_counter_wrap();
    triangle_t t;
    bit        to;
    rdy_mode = 1;
    force dut.frames_sent = 16'hFFFF;
    #1;
    release dut.frames_sent;
    @(negedge clk);
    checks++;
    if (frames_sent !== 16'hFFFF) begin
      failures++; $display("FAIL wrap_preload: got %h expected ffff", frames_sent);
    end
    exp_frames = 16'hFFFF;
    words.delete();
    t = rand_tri();
    offer(t, 1'b1, 1'b0, to);
    wait_words(PW + 1, to);
    checks++;
    if (to || words.size() != PW + 1) begin
      failures++; $display("FAIL wrap_count: got %0d expected %0d", words.size(), PW + 1);
    end
    exp_frames = exp_frames + 16'd1;
    checks++;
    if (frames_sent !== exp_frames) begin
      failures++; $display("FAIL wrap_frames_sent: got %h expected %h", frames_sent, exp_frames);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_backpressure();
    test_random_frames();
    test_back_to_back();
    test_reset_mid_frame();
    test_counter_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/triangle_stream_serializer.md
Name: triangle_stream_serializer

Overview:
- Transmit end of the triangle link. Accepts one triangle_t plus triangle_metadata_t per valid/ready handshake.
- Emits the triangle as a framed stream of DATA_WIDTH-bit words toward the byte-oriented transport (SPI/UART bridge).
- The frame format is identical to the one consumed by the triangle deserializer on the far end. Used for pipeline readback and loopback debug.

Parameters:
- DATA_WIDTH, 8, output word width in bits; must be >= 2.
- SYNC, 7'b1010101, header sync pattern; lower DATA_WIDTH-1 bits are used.
- PAYLOAD_BITS, $bits(triangle_t), payload width; fixed by the types package, not overridden.
- PAYLOAD_WORDS, (PAYLOAD_BITS+DATA_WIDTH-1)/DATA_WIDTH, derived.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rstn  input  1  asynchronous active-low reset
- s_valid  input  1  upstream triangle valid
- s_ready  output  1  serializer can accept a triangle
- s_triangle  input  $bits(triangle_t)  triangle_t to send
- s_metadata  input  $bits(triangle_metadata_t)  triangle_metadata_t; .last marks final triangle of a model
- m_valid  output  1  output word valid
- m_ready  input  1  transport accepts word
- m_data  output  DATA_WIDTH  output word
- m_first  output  1  current word is the frame header
- m_last  output  1  current word is the final payload word of the frame
- frames_sent  output  16  count of completed frames, wraps 0xFFFF->0x0000

Behaviour:
- Reset (rstn low, asynchronous):
  - state=IDLE; s_ready=0 while rstn low.
  - m_valid=0, m_data=0, m_first=0, m_last=0, frames_sent=0, shift register=0.
  - Reset mid-frame discards the partial frame; the receiver resynchronises on the next header.
- Frame layout:
  - Header word = {SYNC[DATA_WIDTH-2:0], metadata.last}.
  - Followed by PAYLOAD_WORDS words of s_triangle, MSB first (v0.position.x leads).
  - Payload is zero-extended on the MSB side to PAYLOAD_WORDS*DATA_WIDTH, so pad zeros appear at the top of the first payload word.
- FSM states IDLE, HEADER, PAYLOAD.
  - IDLE: s_ready=1, m_valid=0. On s_valid&&s_ready: latch the zero-extended triangle into the shift register, build the header, load word counter=PAYLOAD_WORDS-1, go HEADER.
  - HEADER: m_valid=1, m_first=1, m_data=header. On m_ready: go PAYLOAD, present the top word of the shift register.
  - PAYLOAD: m_valid=1, m_data=top word, m_last=(counter==0). On m_ready: shift left by DATA_WIDTH and decrement the counter. If counter==0, go IDLE and increment frames_sent.
- s_ready is combinational from state only (state==IDLE); it never depends on s_valid.
- All m_* outputs are registered. m_data, m_first and m_last hold stable while m_valid && !m_ready. m_valid never drops without a handshake, except on reset.
- Latency:
  - Accept at edge k -> header visible after edge k.
  - With m_ready held high, the last payload word is handshaken at edge k+1+PAYLOAD_WORDS; IDLE follows.
  - Minimum frame period is PAYLOAD_WORDS+2 cycles, with one idle cycle between frames.
- s_triangle and s_metadata are sampled only at acceptance; later changes have no effect on the frame in flight.
- frames_sent increments in the same edge as the final payload handshake and wraps silently.
- PAYLOAD_WORDS==1 is legal: m_first and m_last are never high in the same word, because the header is always a separate word.

Test Plan:
- Reset then idle: rstn low 3 cycles, then high with s_valid=0 -> s_ready=1, m_valid=0, frames_sent=0, m_data=0.
- Single frame, m_ready=1, metadata.last=1, triangle with v0.position.x = all-ones and all other bits 0:
  - First word is 0xAB with m_first=1.
  - Then PAYLOAD_WORDS words matching a reference MSB-first split, pad zeros at the top of word 1.
  - m_last=1 on word PAYLOAD_WORDS only.
  - frames_sent=1.
- Backpressure: same frame with m_ready randomly toggled 50% -> identical word sequence, no word duplicated or dropped, m_data stable during every stall.
- Back-to-back: s_valid held high with two triangles (last=0 then last=1) -> headers 0xAA then 0xAB, exactly one idle cycle between frames, frames_sent=2.
- Reset mid-frame: assert rstn low during payload word 3 -> m_valid falls immediately (asynchronously), frames_sent=0. After release, the next accepted triangle produces a complete fresh frame starting with the header.
- Counter wrap: force frames_sent to 0xFFFF through 65535 frames or a bench backdoor, send one frame -> frames_sent=0x0000.
